// File: rtl/siso_sched.sv
// siso_sched: block-level sequencer for one SISO half-iteration.
// It accepts a block length and gates the forward (alpha) pass while branch
// metrics are written to the branch/alpha buffer. It then reads the buffer in
// reverse for the backward (beta) pass and issues PIPE_LAT-delayed LLR strobes
// that line up with the beta_llr datapath output.
// The block length is N = blklen + TAIL_LEN. Counters hold N-1, so that
// N == 2^ADDR_W still fits in ADDR_W bits.
module siso_sched #(
    parameter int MAX_BLKLEN = 512,
    parameter int TAIL_LEN   = 4,
    parameter int ADDR_W     = 10,
    parameter int PIPE_LAT   = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,        // asynchronous, active-low
    input  logic [15:0]       i_blklen,
    input  logic              i_valid_blklen,
    input  logic              i_valid_branch,
    input  logic              i_abort,
    output logic              o_alpha_en,
    output logic              o_alpha_init,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              o_beta_init,
    output logic              o_llr_en,
    output logic              o_llr_last,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err_blklen
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FWD   = 2'd1;
    localparam logic [1:0] S_BWD   = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    localparam logic [15:0]       LP_MAX_BLKLEN = 16'(MAX_BLKLEN);
    localparam logic [ADDR_W-1:0] LP_TAIL_M1    = ADDR_W'(TAIL_LEN - 1);

    logic [1:0]          r_state;
    logic [ADDR_W-1:0]   r_blklen;     // information length, for tail masking
    logic [ADDR_W-1:0]   r_last_addr;  // N-1
    logic [ADDR_W-1:0]   r_wcnt;
    logic [ADDR_W-1:0]   r_rcnt;
    logic                r_alpha_en;
    logic                r_alpha_init;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic                r_rd_en;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_beta_init;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic [PIPE_LAT-1:0] r_llr_sr;     // LLR-valid delay line
    logic [PIPE_LAT-1:0] r_last_sr;    // LLR-last delay line

    logic w_abort;
    logic w_len_ok;
    logic w_llr_term;
    logic w_last_term;

    // Abort only acts on a block in progress; in IDLE it is a no-op.
    assign w_abort     = i_abort && (r_state != S_IDLE);
    assign w_len_ok    = (i_blklen != 16'd0) && (i_blklen <= LP_MAX_BLKLEN);
    // Tail addresses (>= blklen) are read for beta but never yield an LLR.
    assign w_llr_term  = r_rd_en && (r_rd_addr < r_blklen);
    assign w_last_term = r_rd_en && (r_rd_addr == '0);

    // Block FSM: length acceptance, forward writes, reverse reads, flush.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_blklen     <= '0;
            r_last_addr  <= '0;
            r_wcnt       <= '0;
            r_rcnt       <= '0;
            r_alpha_en   <= 1'b0;
            r_alpha_init <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_rd_en      <= 1'b0;
            r_rd_addr    <= '0;
            r_beta_init  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_alpha_en   <= 1'b0;
            r_alpha_init <= 1'b0;
            r_wr_en      <= 1'b0;
            r_rd_en      <= 1'b0;
            r_beta_init  <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            if (w_abort) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        // A length offered in the done cycle is dropped.
                        if (i_valid_blklen && !r_done) begin
                            if (w_len_ok) begin
                                r_blklen    <= ADDR_W'(i_blklen);
                                r_last_addr <= ADDR_W'(i_blklen) + LP_TAIL_M1;
                                r_wcnt      <= '0;
                                r_busy      <= 1'b1;
                                r_state     <= S_FWD;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    S_FWD: begin
                        if (i_valid_branch) begin
                            r_wr_en      <= 1'b1;
                            r_alpha_en   <= 1'b1;
                            r_alpha_init <= (r_wcnt == '0);
                            r_wr_addr    <= r_wcnt;
                            if (r_wcnt == r_last_addr) begin
                                r_rcnt  <= r_last_addr;
                                r_state <= S_BWD;
                            end else begin
                                r_wcnt <= r_wcnt + 1'b1;
                            end
                        end
                    end
                    S_BWD: begin
                        r_rd_en     <= 1'b1;
                        r_rd_addr   <= r_rcnt;
                        r_beta_init <= (r_rcnt == r_last_addr);
                        if (r_rcnt == '0) begin
                            r_state <= S_FLUSH;
                        end else begin
                            r_rcnt <= r_rcnt - 1'b1;
                        end
                    end
                    default: begin
                        // llr_last marks the final delay-line entry; the
                        // line is empty right after it.
                        if (r_last_sr[PIPE_LAT-1]) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    // Delay lines matching the beta_llr pipeline latency; abort empties them.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_llr_sr  <= '0;
            r_last_sr <= '0;
        end else if (w_abort) begin
            r_llr_sr  <= '0;
            r_last_sr <= '0;
        end else begin
            for (int i = PIPE_LAT - 1; i > 0; i--) begin
                r_llr_sr[i]  <= r_llr_sr[i-1];
                r_last_sr[i] <= r_last_sr[i-1];
            end
            r_llr_sr[0]  <= w_llr_term;
            r_last_sr[0] <= w_last_term;
        end
    end

    assign o_alpha_en   = r_alpha_en;
    assign o_alpha_init = r_alpha_init;
    assign o_wr_en      = r_wr_en;
    assign o_wr_addr    = r_wr_addr;
    assign o_rd_en      = r_rd_en;
    assign o_rd_addr    = r_rd_addr;
    assign o_beta_init  = r_beta_init;
    assign o_llr_en     = r_llr_sr[PIPE_LAT-1];
    assign o_llr_last   = r_last_sr[PIPE_LAT-1];
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_err_blklen = r_err;

endmodule

// File: tb/tb_siso_sched.sv
// Testbench for siso_sched: directed block scenarios with randomized gaps,
// lengths and abort points. Expected strobes come from cycle-offset arithmetic
// relative to the last buffer write.
`timescale 1ns/1ps
module tb_siso_sched;

    localparam int MAXB = 512;
    localparam int TAIL = 4;
    localparam int AW   = 10;
    localparam int PL   = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   blklen = '0;
    logic          vbl = 1'b0;
    logic          vbr = 1'b0;
    logic          abort = 1'b0;
    logic          alpha_en, alpha_init, wr_en, rd_en, beta_init;
    logic          llr_en, llr_last, busy, done, err;
    logic [AW-1:0] wr_addr, rd_addr;

    int checks = 0;
    int errors = 0;

    siso_sched #(
        .MAX_BLKLEN(MAXB), .TAIL_LEN(TAIL), .ADDR_W(AW), .PIPE_LAT(PL)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_blklen(blklen),
        .i_valid_blklen(vbl), .i_valid_branch(vbr), .i_abort(abort),
        .o_alpha_en(alpha_en), .o_alpha_init(alpha_init), .o_wr_en(wr_en),
        .o_wr_addr(wr_addr), .o_rd_en(rd_en), .o_rd_addr(rd_addr),
        .o_beta_init(beta_init), .o_llr_en(llr_en), .o_llr_last(llr_last),
        .o_busy(busy), .o_done(done), .o_err_blklen(err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Packed view of the single-bit outputs.
    function automatic logic [9:0] ovec();
        return {alpha_en, alpha_init, wr_en, rd_en, beta_init,
                llr_en, llr_last, busy, done, err};
    endfunction

    function automatic logic [9:0] ev(input bit ae, input bit ai, input bit we,
                                      input bit re, input bit bi, input bit le,
                                      input bit ll, input bit bs, input bit dn,
                                      input bit er);
        return {ae, ai, we, re, bi, le, ll, bs, dn, er};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete block. mode: 0 continuous, 1 toggling, 2 random gaps.
    // abort_addr >= 0 aborts in the cycle where that read address shows.
    task automatic run_block(input int B, input int mode, input int abort_addr,
                             input bit hold, input bit abort_acc);
        int  N, k, it, nllr, r, q;
        bit  vb, e_rd, e_ll, e_lst, e_dn, e_bs;
        N = B + TAIL;
        nllr = 0;
        blklen = 16'(B);
        vbl = 1'b1;
        vbr = 1'($urandom);
        abort = abort_acc;
        step();
        vbl = hold;
        abort = 1'b0;
        chk("accept", 32'(ovec()), 32'(ev(0,0,0,0,0,0,0,1,0,0)));

        k = 0;
        it = 0;
        while (k < N && it < 20000) begin
            case (mode)
                0:       vb = 1'b1;
                1:       vb = (it % 2 == 0);
                default: vb = ($urandom_range(0, 2) != 0);
            endcase
            vbr = vb;
            if (!hold) blklen = 16'($urandom);
            step();
            it++;
            chk("fwd", 32'(ovec()), 32'(ev(vb, vb && k == 0, vb, 0, 0, 0, 0, 1, 0, 0)));
            if (vb) begin
                chk("wr_addr", 32'(wr_addr), 32'(k));
                k++;
            end
        end
        if (k < N) chk("fwd_bound", 32'(k), 32'(N));

        // Offsets counted from the cycle of the last write.
        for (int s = 1; s <= N + PL + 2; s++) begin
            vbr = 1'($urandom);
            step();
            r     = s - 1;
            q     = s - 1 - PL;
            e_rd  = (r < N);
            e_ll  = (q >= 0) && (q < N) && ((N - 1 - q) < B);
            e_lst = (q == N - 1);
            e_dn  = (s == N + PL + 1);
            e_bs  = (s < N + PL + 1);
            chk("bwd", 32'(ovec()),
                32'(ev(0, 0, 0, e_rd, e_rd && r == 0, e_ll, e_lst, e_bs, e_dn, 0)));
            if (e_rd) chk("rd_addr", 32'(rd_addr), 32'(N - 1 - r));
            if (llr_en) nllr++;
            if (e_rd && (N - 1 - r) == abort_addr) begin
                abort = 1'b1;
                vbr = 1'b0;
                step();
                abort = 1'b0;
                chk("abort", 32'(ovec()), 32'(0));
                for (int i = 0; i < PL + 4; i++) begin
                    step();
                    chk("post_abort", 32'(ovec()), 32'(0));
                end
                return;
            end
        end
        vbr = 1'b0;
        chk("llr_count", 32'(nllr), 32'(B));
    endtask

    task automatic bad_len(input logic [15:0] L);
        blklen = L;
        vbl = 1'b1;
        step();
        vbl = 1'b0;
        chk("err_pulse", 32'(ovec()), 32'(ev(0,0,0,0,0,0,0,0,0,1)));
        step();
        chk("err_clear", 32'(ovec()), 32'(0));
    endtask

    initial begin
        int B, N, ab;
        // Reset state
        #2;
        chk("reset", 32'(ovec()), 32'(0));
        chk("reset_addr", 32'({wr_addr, rd_addr}), 32'(0));
        step();
        rst_n = 1'b1;

        // Nominal, gapped
        run_block(40, 0, -1, 1'b0, 1'b0);
        run_block(8, 1, -1, 1'b0, 1'b0);

        // Illegal lengths, then the largest legal one
        bad_len(16'd0);
        bad_len(16'd513);
        bad_len(16'hFFFF);
        run_block(512, 0, -1, 1'b0, 1'b0);

        // Abort in BWD, then a normal block
        run_block(40, 2, 20, 1'b0, 1'b0);
        run_block(16, 0, -1, 1'b0, 1'b0);

        // Abort in IDLE has no effect, also alongside an acceptance
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_idle", 32'(ovec()), 32'(0));
        run_block(10, 1, -1, 1'b0, 1'b1);

        // Asynchronous reset mid-FWD
        blklen = 16'd20;
        vbl = 1'b1;
        step();
        vbr = 1'b1;
        repeat (5) step();
        chk("pre_reset", 32'(ovec()), 32'(ev(1,0,1,0,0,0,0,1,0,0)));
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 32'(ovec()), 32'(0));
        chk("async_reset_addr", 32'({wr_addr, rd_addr}), 32'(0));
        step();
        chk("reset_hold0", 32'(ovec()), 32'(0));
        step();
        chk("reset_hold1", 32'(ovec()), 32'(0));
        #2;
        rst_n = 1'b1;
        vbl = 1'b0;
        vbr = 1'b0;
        step();
        chk("post_reset_idle", 32'(ovec()), 32'(0));

        // Back-to-back with valid_blklen held through done
        run_block(10, 0, -1, 1'b1, 1'b0);
        run_block(12, 2, -1, 1'b0, 1'b0);

        // Randomized blocks with occasional aborts
        for (int b = 0; b < 5; b++) begin
            B  = $urandom_range(1, 70);
            N  = B + TAIL;
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N - 1)) : -1;
            run_block(B, 2, ab, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/siso_sched.md
Name: siso_sched

Overview:
- Block-level sequencer for one SISO half-iteration.
- Accepts a block length, then gates the forward (alpha) pass while branch metrics are written to a branch/alpha buffer.
- Then runs the backward (beta) pass by reading that buffer in reverse, and issues LLR-valid strobes.
- Sits between init_branch/alpha and the beta_llr datapath; replaces the free-running counters in beta_llr.

Parameters:
- MAX_BLKLEN, 512, largest accepted information block length.
- TAIL_LEN, 4, trellis termination steps appended to every block.
- ADDR_W, 10, buffer address width; must satisfy 2^ADDR_W >= MAX_BLKLEN+TAIL_LEN.
- PIPE_LAT, 4, cycles from rd_en to the matching LLR leaving beta_llr.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- blklen  in  16  information block length.
- valid_blklen  in  1  blklen qualifier; sampled only in IDLE.
- valid_branch  in  1  one branch-metric pair available this cycle (from init_branch).
- abort  in  1  synchronous abort of the current block.
- alpha_en  out  1  advance alpha recursion.
- alpha_init  out  1  load alpha start metrics (state 0 = 0, others = most negative).
- wr_en  out  1  buffer write strobe.
- wr_addr  out  ADDR_W  buffer write address.
- rd_en  out  1  buffer read strobe.
- rd_addr  out  ADDR_W  buffer read address.
- beta_init  out  1  load beta terminal metrics.
- llr_en  out  1  LLR output valid.
- llr_last  out  1  last LLR of block.
- busy  out  1  block in progress.
- done  out  1  one-cycle block-complete pulse.
- err_blklen  out  1  one-cycle illegal-length pulse.

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; counters 0; LLR delay line cleared.
- All outputs registered; N = blklen+TAIL_LEN, latched on acceptance.
- IDLE:
  - valid_blklen with 1 <= blklen <= MAX_BLKLEN: latch blklen and N; next state FWD; busy=1 from the next cycle.
  - valid_blklen with blklen=0 or blklen>MAX_BLKLEN: err_blklen pulse next cycle; stay IDLE.
  - valid_branch in IDLE is ignored.
- FWD:
  - Each cycle with valid_branch: next cycle wr_en=1, alpha_en=1, wr_addr=k (k=0..N-1, increment per accepted metric). Gaps in valid_branch are allowed and produce no strobes.
  - alpha_init=1 together with alpha_en for k=0 only.
  - After the valid_branch for k=N-1: go to BWD.
- BWD:
  - rd_en=1 every cycle with rd_addr descending N-1..0, starting the cycle after the last wr_en. No read ever precedes its write.
  - beta_init=1 together with rd_addr=N-1.
  - After rd_addr=0: go to FLUSH.
  - valid_branch in BWD or FLUSH: ignored (upstream must hold off until done).
- LLR timing:
  - llr_en is the term (rd_en AND rd_addr < blklen) delayed exactly PIPE_LAT cycles; tail addresses never produce llr_en.
  - llr_last is (rd_en AND rd_addr==0) delayed PIPE_LAT cycles.
  - Exactly blklen llr_en pulses per block.
- FLUSH: wait until the delay line is empty. done=1 for one cycle in the cycle after llr_last. busy deasserts with done; state returns to IDLE.
- Back-to-back blocks: a valid_blklen in the same cycle as done is ignored; one can be accepted from the following cycle.
- valid_blklen outside IDLE: ignored; no error pulse.
- abort (any state except IDLE):
  - Next cycle: IDLE, busy=0, delay line cleared, no done.
  - All strobes 0 from that cycle on.
  - abort in IDLE: no effect.
- Counters are ADDR_W wide and never wrap, since N <= 2^ADDR_W by parameter constraint.

Test Plan:
- Nominal:
  - Stimulus: blklen=40 with continuous valid_branch.
  - Response: 44 wr_en at addresses 0..43, alpha_init only at address 0; then 44 rd_en at 43..0, beta_init at 43.
  - Response: 40 llr_en, the first PIPE_LAT=4 cycles after rd_addr=39; llr_last 4 cycles after rd_addr=0; done one cycle later.
- Gapped input:
  - Stimulus: blklen=8, valid_branch toggling 1/0.
  - Response: 12 writes, addresses contiguous 0..11, alpha_en only on write cycles; BWD starts the cycle after the write to address 11.
- Illegal length:
  - Stimulus: blklen=0, then blklen=513.
  - Response: an err_blklen pulse for each; busy stays 0; no strobes.
  - Then blklen=512: N=516, last wr_addr=515, 512 llr_en.
- Abort:
  - Stimulus: abort during BWD at rd_addr=20.
  - Response: busy=0 and rd_en=0 next cycle; no further llr_en; no done.
  - A new blklen=16 is accepted next and completes normally.
- Async reset mid-FWD:
  - Stimulus: rst=0 between clock edges.
  - Response: all outputs 0 immediately, without waiting for a clock edge; valid_blklen ignored while rst=0.
- Back-to-back:
  - Stimulus: valid_blklen held high through done.
  - Response: the second block is accepted one cycle after done; its wr_addr restarts at 0.
